// File: rtl/oam_dma_arbiter.sv
// OAM DMA engine and shared memory port arbiter.
// Owns the FF46 source register and copies XFER_LEN bytes into OAM, yielding the port to high-page core accesses.
module oam_dma_arbiter #(
  parameter logic [15:0] DMA_REG_ADDR = 16'hFF46,
  parameter logic [15:0] OAM_BASE     = 16'hFE00,
  parameter int          XFER_LEN     = 160
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  output logic [7:0]  cpu_rdata,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic [7:0]  mem_rdata,
  output logic        dma_active
);

  // state  | meaning
  // IDLE   | no transfer, core owns the port
  // START  | one-cycle lead-in after an FF46 write, no DMA traffic
  // READ   | fetch source byte {src_mapped, idx} into data_buf
  // WRITE  | store data_buf to OAM_BASE + idx, advance idx
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_READ  = 2'd2;
  localparam logic [1:0] ST_WRITE = 2'd3;

  localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

  logic [1:0] state;
  logic [7:0] src;
  logic [7:0] idx;
  logic [7:0] data_buf;

  logic       is_dma_reg;
  logic       core_rd;
  logic       core_wr;
  logic       reg_wr;
  logic       reg_rd;
  logic       high_page_acc;
  logic       core_owns;
  logic       dma_bus;
  logic [7:0] src_mapped;

  // Simultaneous read and write strobes resolve to a write.
  assign core_wr    = cpu_wr;
  assign core_rd    = cpu_rd & ~cpu_wr;
  assign is_dma_reg = (cpu_addr == DMA_REG_ADDR);
  assign reg_wr     = core_wr & is_dma_reg;
  assign reg_rd     = core_rd & is_dma_reg;

  assign high_page_acc = (core_rd | core_wr) & (cpu_addr[15:8] == 8'hFF) & ~is_dma_reg;

  assign dma_active = (state != ST_IDLE);
  assign core_owns  = dma_active & high_page_acc;
  assign dma_bus    = ((state == ST_READ) || (state == ST_WRITE)) & ~core_owns;

  // Echo RAM sources E0-FF fold back onto work RAM C0-DF.
  assign src_mapped = (src >= 8'hE0) ? (src - 8'h20) : src;

  always_comb begin
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    cpu_rdata = 8'hFF;

    if (!dma_active || core_owns) begin
      mem_rd    = core_rd & ~is_dma_reg;
      mem_wr    = core_wr & ~is_dma_reg;
      cpu_rdata = mem_rdata;
    end else if (dma_bus) begin
      if (state == ST_READ) begin
        mem_addr = {src_mapped, idx};
        mem_rd   = 1'b1;
      end else begin
        mem_addr  = OAM_BASE + {8'h00, idx};
        mem_wdata = data_buf;
        mem_wr    = 1'b1;
      end
    end

    if (reg_rd) begin
      cpu_rdata = src;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= ST_IDLE;
      src      <= 8'h00;
      idx      <= 8'h00;
      data_buf <= 8'h00;
    end else if (reg_wr) begin
      src   <= cpu_wdata;
      idx   <= 8'h00;
      state <= ST_START;
    end else begin
      case (state)
        ST_START: state <= ST_READ;
        ST_READ: begin
          if (dma_bus) begin
            data_buf <= mem_rdata;
            state    <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (dma_bus) begin
            idx   <= idx + 8'd1;
            state <= (idx == LAST_IDX) ? ST_IDLE : ST_READ;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Self-checking bench for oam_dma_arbiter: passthrough vector table plus DMA transfer sequences.
// A 64 KiB memory model sits on the shared port; all contents are loaded and read back through the core.
module tb_oam_dma_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] cpu_addr = 16'h0000;
  logic [7:0]  cpu_wdata = 8'h00;
  logic        cpu_rd = 1'b0;
  logic        cpu_wr = 1'b0;
  logic [7:0]  cpu_rdata;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_rd;
  logic        mem_wr;
  logic [7:0]  mem_rdata;
  logic        dma_active;

  logic [7:0]  mem [0:65535];

  int n_pass = 0;
  int n_total = 0;
  int act_cnt = 0;
  int oam_wr_cnt = 0;

  always #5 clock = ~clock;

  oam_dma_arbiter dut (
    .clock      (clock),
    .reset      (reset),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rd     (cpu_rd),
    .cpu_wr     (cpu_wr),
    .cpu_rdata  (cpu_rdata),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .mem_rdata  (mem_rdata),
    .dma_active (dma_active)
  );

  assign mem_rdata = mem[mem_addr];

  always @(posedge clock) begin
    if (mem_wr) mem[mem_addr] <= mem_wdata;
  end

  always @(negedge clock) begin
    if (dma_active) act_cnt <= act_cnt + 1;
    if (mem_wr && mem_addr >= 16'hFE00 && mem_addr <= 16'hFE9F) oam_wr_cnt <= oam_wr_cnt + 1;
  end

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        rd;
    logic        wr;
    logic        exp_rd;
    logic        exp_wr;
    logic [7:0]  exp_rdata;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Drive a core access right after an edge; outputs are stable by the following negedge.
  task automatic cpu_op(input logic [15:0] a, input logic [7:0] d, input logic rd, input logic wr,
                        output logic [7:0] rdata);
    @(posedge clock);
    #1;
    cpu_addr = a; cpu_wdata = d; cpu_rd = rd; cpu_wr = wr;
    @(negedge clock);
    rdata = cpu_rdata;
  endtask

  task automatic bus_idle();
    @(posedge clock);
    #1;
    cpu_rd = 1'b0; cpu_wr = 1'b0;
  endtask

  task automatic fill(input logic [15:0] base, input logic [7:0] key, input int n);
    logic [7:0] r;
    for (int i = 0; i < n; i++) cpu_op(base + 16'(i), 8'(i) ^ key, 1'b0, 1'b1, r);
    bus_idle();
  endtask

  task automatic check_oam(input string name, input logic [15:0] first, input int n,
                           input logic use_idx, input logic [7:0] key);
    logic [7:0] r;
    logic [7:0] e;
    for (int i = 0; i < n; i++) begin
      cpu_op(first + 16'(i), 8'h00, 1'b1, 1'b0, r);
      e = use_idx ? (8'(first[7:0] + 8'(i)) ^ key) : key;
      chk(name, {8'h00, r}, {8'h00, e});
    end
    bus_idle();
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (dma_active && n < budget) begin
      @(negedge clock);
      n++;
    end
    chk("wait_idle_timeout", {15'h0, dma_active}, 16'h0);
  endtask

  // Waits (inputs idle) until the shared port shows the given strobe/address; true on success.
  task automatic wait_port(input logic want_wr, input logic [15:0] a, input int budget, output logic found);
    found = 1'b0;
    for (int n = 0; n < budget && !found; n++) begin
      @(posedge clock);
      #1;
      cpu_rd = 1'b0; cpu_wr = 1'b0;
      #1;
      if ((want_wr ? mem_wr : mem_rd) && mem_addr == a) found = 1'b1;
    end
    chk("wait_port_timeout", {15'h0, found}, 16'h1);
  endtask

  initial begin
    logic [7:0]  r;
    logic        found;
    logic [15:0] saved;
    int          a0, w0;

    vecs[0] = '{16'hC000, 8'h11, 1'b0, 1'b1, 1'b0, 1'b1, 8'hFF};
    vecs[1] = '{16'hC000, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h11};
    vecs[2] = '{16'hC010, 8'h77, 1'b1, 1'b1, 1'b0, 1'b1, 8'hFF};
    vecs[3] = '{16'hC010, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h77};
    vecs[4] = '{16'hFF46, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[5] = '{16'hFF85, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b1, 8'hFF};
    vecs[6] = '{16'hFF85, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA5};
    vecs[7] = '{16'h1234, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF};

    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    #1;
    chk("reset_dma_active", {15'h0, dma_active}, 16'h0);

    // Idle passthrough table
    for (int i = 0; i < 8; i++) begin
      cpu_op(vecs[i].addr, vecs[i].wdata, vecs[i].rd, vecs[i].wr, r);
      chk("vec_mem_rd", {15'h0, mem_rd}, {15'h0, vecs[i].exp_rd});
      chk("vec_mem_wr", {15'h0, mem_wr}, {15'h0, vecs[i].exp_wr});
      chk("vec_dma_active", {15'h0, dma_active}, 16'h0);
      if (vecs[i].exp_rd || vecs[i].exp_wr) chk("vec_mem_addr", mem_addr, vecs[i].addr);
      if (vecs[i].exp_wr) chk("vec_mem_wdata", {8'h00, mem_wdata}, {8'h00, vecs[i].wdata});
      if (vecs[i].rd && !vecs[i].wr) chk("vec_cpu_rdata", {8'h00, r}, {8'h00, vecs[i].exp_rdata});
    end
    bus_idle();

    fill(16'hC100, 8'h5A, 160);
    fill(16'hC200, 8'hA5, 160);
    fill(16'hD000, 8'hC3, 160);

    // Nominal transfer from C1
    a0 = act_cnt; w0 = oam_wr_cnt;
    cpu_op(16'hFF46, 8'hC1, 1'b0, 1'b1, r);
    chk("ff46_wr_not_forwarded", {15'h0, mem_wr}, 16'h0);
    bus_idle();
    wait_idle(400);
    chk("nominal_active_cycles", 16'(act_cnt - a0), 16'd321);
    chk("nominal_oam_writes", 16'(oam_wr_cnt - w0), 16'd160);
    check_oam("nominal_oam_data", 16'hFE00, 160, 1'b1, 8'h5A);

    // Blocked low-page access and high-page stall in one transfer
    a0 = act_cnt; w0 = oam_wr_cnt;
    cpu_op(16'hFF46, 8'hC1, 1'b0, 1'b1, r);
    bus_idle();
    repeat (5) bus_idle();
    cpu_op(16'hC000, 8'h00, 1'b1, 1'b0, r);
    chk("blocked_rd_data", {8'h00, r}, 16'h00FF);
    chk("blocked_rd_no_strobe", {15'h0, mem_rd && mem_addr == 16'hC000}, 16'h0);
    cpu_op(16'hC000, 8'h12, 1'b0, 1'b1, r);
    chk("blocked_wr_no_strobe", {15'h0, mem_wr && mem_addr == 16'hC000}, 16'h0);
    wait_port(1'b0, 16'hC10A, 60, found);
    saved = mem_addr;
    cpu_addr = 16'hFF85; cpu_rd = 1'b1;
    #1;
    chk("hi_rd_mem_addr", mem_addr, 16'hFF85);
    chk("hi_rd_mem_rd", {15'h0, mem_rd}, 16'h1);
    chk("hi_rd_cpu_rdata", {8'h00, cpu_rdata}, 16'h00A5);
    @(posedge clock);
    #1 cpu_rd = 1'b0;
    #1;
    chk("stall_resume_addr", mem_addr, saved);
    chk("stall_resume_rd", {15'h0, mem_rd}, 16'h1);
    wait_idle(400);
    chk("stall_active_cycles", 16'(act_cnt - a0), 16'd322);
    chk("stall_oam_writes", 16'(oam_wr_cnt - w0), 16'd160);
    cpu_op(16'hC000, 8'h00, 1'b1, 1'b0, r);
    chk("blocked_wr_dropped", {8'h00, r}, 16'h0011);
    bus_idle();

    // Echo source E2 folds to C2
    cpu_op(16'hFF46, 8'hE2, 1'b0, 1'b1, r);
    bus_idle();
    wait_idle(400);
    check_oam("echo_oam_data", 16'hFE00, 160, 1'b1, 8'hA5);
    cpu_op(16'hFF46, 8'h00, 1'b1, 1'b0, r);
    chk("ff46_readback_e2", {8'h00, r}, 16'h00E2);
    chk("ff46_rd_no_strobe", {15'h0, mem_rd}, 16'h0);
    bus_idle();

    // Restart at idx 50 with a new source
    cpu_op(16'hFF46, 8'hC1, 1'b0, 1'b1, r);
    bus_idle();
    wait_port(1'b1, 16'hFE32, 200, found);
    cpu_addr = 16'hFF46; cpu_wdata = 8'hD0; cpu_wr = 1'b1;
    #1;
    chk("restart_inflight_wr", {15'h0, mem_wr}, 16'h1);
    chk("restart_inflight_addr", mem_addr, 16'hFE32);
    @(posedge clock);
    #1 cpu_wr = 1'b0;
    #1;
    chk("restart_start_active", {15'h0, dma_active}, 16'h1);
    chk("restart_start_quiet", {15'h0, mem_rd | mem_wr}, 16'h0);
    bus_idle();
    #1;
    chk("restart_first_rd", mem_addr, 16'hD000);
    wait_idle(400);
    check_oam("restart_oam_data", 16'hFE00, 160, 1'b1, 8'hC3);

    // Reset during transfer at idx 80
    fill(16'hFE00, 8'hEE, 0);
    for (int i = 0; i < 160; i++) cpu_op(16'hFE00 + 16'(i), 8'hEE, 1'b0, 1'b1, r);
    bus_idle();
    cpu_op(16'hFF46, 8'hC1, 1'b0, 1'b1, r);
    bus_idle();
    wait_port(1'b0, 16'hC150, 200, found);
    reset = 1'b0;
    @(posedge clock);
    #1 reset = 1'b1;
    #1;
    chk("reset_mid_active", {15'h0, dma_active}, 16'h0);
    chk("reset_mid_no_wr", {15'h0, mem_wr}, 16'h0);
    cpu_op(16'hFF46, 8'h00, 1'b1, 1'b0, r);
    chk("reset_ff46_read", {8'h00, r}, 16'h0000);
    bus_idle();
    check_oam("reset_done_part", 16'hFE00, 80, 1'b1, 8'h5A);
    check_oam("reset_untouched", 16'hFE50, 80, 1'b0, 8'hEE);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
